// File: rtl/button_debounce.sv
`timescale 1ns/1ps
// button_debounce: synchronises a raw push-button, debounces it with a
// stable-cycle counter and a four-state FSM, and produces a clean level,
// one-cycle press/release pulses and a wrapping count of debounced presses.
//
// Handshake: there is no valid/ready channel. btn_press and btn_release are
// single-cycle strobes: each is high for exactly one clk cycle per debounced
// edge and they are never high together. btn_level and press_cnt are plain
// registered levels. state_dbg exposes the FSM state for observation only.
module button_debounce #(
   parameter int DEBOUNCE_WIDTH = 12,
   parameter int DEBOUNCE_COUNT = 999
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_in,
   output logic       btn_level,
   output logic       btn_press,
   output logic       btn_release,
   output logic [7:0] press_cnt,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      ARM_PRESS   = 2'd1,
      PRESSED     = 2'd2,
      ARM_RELEASE = 2'd3
   } state_t;

   localparam logic [DEBOUNCE_WIDTH-1:0] CNT_MAX = DEBOUNCE_WIDTH'(DEBOUNCE_COUNT);
   localparam logic [DEBOUNCE_WIDTH-1:0] CNT_ONE = DEBOUNCE_WIDTH'(1);

   state_t                    state_q, state_d;
   logic                      sync1_q, sync1_d;
   logic                      sync2_q, sync2_d;
   logic [DEBOUNCE_WIDTH-1:0] cnt_q, cnt_d;
   logic                      level_q, level_d;
   logic                      press_q, press_d;
   logic                      release_q, release_d;
   logic [7:0]                press_cnt_q, press_cnt_d;

   // Next-state logic: synchroniser shift, debounce FSM and its outputs.
   // The counter restarts whenever the FSM arms, so cnt never exceeds
   // CNT_MAX and needs no overflow handling.
   always_comb begin
      sync1_d     = btn_in;
      sync2_d     = sync1_q;
      state_d     = state_q;
      cnt_d       = cnt_q;
      level_d     = level_q;
      press_d     = 1'b0;
      release_d   = 1'b0;
      press_cnt_d = press_cnt_q;
      case (state_q)
         IDLE: begin
            if (sync2_q) begin
               state_d = ARM_PRESS;
               cnt_d   = '0;
            end
         end
         ARM_PRESS: begin
            if (!sync2_q) begin
               // Bounce: fall back without any pulse.
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d     = PRESSED;
               level_d     = 1'b1;
               press_d     = 1'b1;
               press_cnt_d = press_cnt_q + 8'd1;
               cnt_d       = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         PRESSED: begin
            if (!sync2_q) begin
               state_d = ARM_RELEASE;
               cnt_d   = '0;
            end
         end
         ARM_RELEASE: begin
            if (sync2_q) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d   = IDLE;
               level_d   = 1'b0;
               release_d = 1'b1;
               cnt_d     = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State registers with synchronous reset; reset drops any pending pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         state_q     <= IDLE;
         cnt_q       <= '0;
         level_q     <= 1'b0;
         press_q     <= 1'b0;
         release_q   <= 1'b0;
         press_cnt_q <= 8'd0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         level_q     <= level_d;
         press_q     <= press_d;
         release_q   <= release_d;
         press_cnt_q <= press_cnt_d;
      end
   end

   assign btn_level   = level_q;
   assign btn_press   = press_q;
   assign btn_release = release_q;
   assign press_cnt   = press_cnt_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_button_debounce.sv
`timescale 1ns/1ps
// Bench for button_debounce. Two instances share clk/rst: a slow one with the
// default 999-cycle threshold and a fast one (threshold 7, 3-bit counter) used
// for the 256-press wrap test. A run-length reference model predicts every
// pulse into a queue; a negedge monitor pops and compares.
module tb_button_debounce;

   localparam int SW = 12;
   localparam int SC = 999;
   localparam int FW = 3;
   localparam int FC = 7;
   localparam int EW = 41;   // {is_press, press_cnt[7:0], cycle[31:0]}

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] btn = 2'b00;
   logic       lvl0, prs0, rel0, lvl1, prs1, rel1;
   logic [7:0] pc0, pc1;
   logic [1:0] dbg0, dbg1;

   // Clock and reset block
   always #40 clk = ~clk;

   button_debounce #(.DEBOUNCE_WIDTH(SW), .DEBOUNCE_COUNT(SC)) u_slow (
      .clk(clk), .rst(rst), .btn_in(btn[0]), .btn_level(lvl0), .btn_press(prs0),
      .btn_release(rel0), .press_cnt(pc0), .state_dbg(dbg0));

   button_debounce #(.DEBOUNCE_WIDTH(FW), .DEBOUNCE_COUNT(FC)) u_fast (
      .clk(clk), .rst(rst), .btn_in(btn[1]), .btn_level(lvl1), .btn_press(prs1),
      .btn_release(rel1), .press_cnt(pc1), .state_dbg(dbg1));

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   bit chk_en = 1'b0;

   logic [EW-1:0] exp_q0[$];
   logic [EW-1:0] exp_q1[$];

   // Reference model state, per instance
   int m_s1[2], m_s2[2], m_lvl[2], m_run[2], m_pc[2];
   int n_press[2], n_rel[2], last_p[2], last_r[2];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic int thr(input int i);
      return (i == 0) ? SC : FC;
   endfunction

   // Reference model: the debounced level flips once the synchronised input
   // (the raw input two edges late) has disagreed with it on threshold+2
   // consecutive edges; any agreeing edge restarts the run.
   always @(posedge clk) begin
      cyc = cyc + 1;
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_run[i] = 0; m_pc[i] = 0;
         end else begin
            if (m_s2[i] != m_lvl[i]) begin
               m_run[i] = m_run[i] + 1;
               if (m_run[i] == thr(i) + 2) begin
                  m_lvl[i] = 1 - m_lvl[i];
                  m_run[i] = 0;
                  if (m_lvl[i] != 0) m_pc[i] = (m_pc[i] + 1) % 256;
                  if (i == 0) exp_q0.push_back({1'(m_lvl[i]), 8'(m_pc[i]), 32'(cyc)});
                  else        exp_q1.push_back({1'(m_lvl[i]), 8'(m_pc[i]), 32'(cyc)});
               end
            end else begin
               m_run[i] = 0;
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = int'(btn[i]);
         end
      end
   end

   function automatic int q_size(input int i);
      return (i == 0) ? exp_q0.size() : exp_q1.size();
   endfunction

   function automatic logic [EW-1:0] q_pop(input int i);
      return (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
   endfunction

   function automatic logic [EW-1:0] q_front(input int i);
      return (i == 0) ? exp_q0[0] : exp_q1[0];
   endfunction

   // Scoreboard monitor for one instance
   task automatic mon(input int i, input logic p, input logic r, input logic l, input logic [7:0] pc);
      logic [EW-1:0] e;
      chk($sformatf("level%0d", i), 64'(l), 64'(m_lvl[i]));
      chk($sformatf("press_cnt%0d", i), 64'(pc), 64'(m_pc[i]));
      while (q_size(i) > 0 && int'(q_front(i)[31:0]) < cyc) begin
         e = q_pop(i);
         chk($sformatf("pulse_missed%0d", i), 64'(0), 64'(e[31:0]));
      end
      if (p && r) chk($sformatf("overlap%0d", i), 64'(1), 64'(0));
      if (p || r) begin
         if (p) begin n_press[i]++; last_p[i] = cyc; end
         if (r) begin n_rel[i]++;   last_r[i] = cyc; end
         if (q_size(i) == 0) begin
            chk($sformatf("unexpected_pulse%0d", i), 64'(cyc), 64'(0));
         end else begin
            e = q_pop(i);
            chk($sformatf("pulse_kind%0d", i), 64'(p), 64'(e[40]));
            chk($sformatf("pulse_cnt%0d", i), 64'(pc), 64'(e[39:32]));
            chk($sformatf("pulse_cycle%0d", i), 64'(cyc), 64'(e[31:0]));
         end
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         mon(0, prs0, rel0, lvl0, pc0);
         mon(1, prs1, rel1, lvl1, pc1);
      end
   end

   // Driver tasks
   task automatic hold(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic drive(input int i, input logic v, input int n);
      btn[i] = v;
      hold(n);
   endtask

   int c0, p0, r0;

   initial begin
      // 1. reset and idle
      hold(3);
      rst = 1'b0;
      chk_en = 1'b1;
      chk("rst_level", 64'(lvl0), 64'(0));
      chk("rst_press", 64'(prs0), 64'(0));
      chk("rst_release", 64'(rel0), 64'(0));
      chk("rst_cnt", 64'(pc0), 64'(0));
      hold(2000);
      chk("idle_level", 64'(lvl0), 64'(0));
      chk("idle_pulses", 64'(n_press[0] + n_rel[0]), 64'(0));

      // 3. bounces shorter than threshold are rejected
      for (int k = 0; k < 10; k++) drive(0, ~k[0], 100);
      drive(0, 1'b0, 1200);
      chk("bounce_press", 64'(n_press[0]), 64'(0));
      chk("bounce_level", 64'(lvl0), 64'(0));
      chk("bounce_cnt", 64'(pc0), 64'(0));

      // 2. clean press
      btn[0] = 1'b1; c0 = cyc;
      hold(2000);
      chk("press_count", 64'(n_press[0]), 64'(1));
      chk("press_edge", 64'(last_p[0] - c0), 64'(SC + 4));
      chk("press_level", 64'(lvl0), 64'(1));
      chk("press_cnt", 64'(pc0), 64'(1));
      chk("press_no_release", 64'(n_rel[0]), 64'(0));

      // 4. release with three bounces
      for (int k = 0; k < 6; k++) drive(0, k[0], 50);
      btn[0] = 1'b0; c0 = cyc;
      hold(1200);
      chk("release_count", 64'(n_rel[0]), 64'(1));
      chk("release_edge", 64'(last_r[0] - c0), 64'(SC + 4));
      chk("release_level", 64'(lvl0), 64'(0));

      // bring press_cnt to 5 and hold pressed
      for (int k = 0; k < 3; k++) begin
         drive(0, 1'b1, 1100);
         drive(0, 1'b0, 1100);
      end
      drive(0, 1'b1, 1100);
      chk("pre_rst_cnt", 64'(pc0), 64'(5));
      chk("pre_rst_level", 64'(lvl0), 64'(1));

      // 6. reset while held
      rst = 1'b1;
      hold(1);
      chk("midrst_level", 64'(lvl0), 64'(0));
      chk("midrst_cnt", 64'(pc0), 64'(0));
      hold(1);
      rst = 1'b0; c0 = cyc; p0 = n_press[0];
      hold(1200);
      chk("rearm_press", 64'(n_press[0] - p0), 64'(1));
      chk("rearm_edge", 64'(last_p[0] - c0), 64'(SC + 4));
      chk("rearm_cnt", 64'(pc0), 64'(1));

      // 5. wrap test on the fast instance
      p0 = n_press[1]; r0 = n_rel[1];
      for (int k = 1; k <= 256; k++) begin
         drive(1, 1'b1, 20);
         if (k == 255) chk("wrap_255", 64'(pc1), 64'(255));
         if (k == 256) chk("wrap_0", 64'(pc1), 64'(0));
         drive(1, 1'b0, 20);
      end
      chk("wrap_presses", 64'(n_press[1] - p0), 64'(256));
      chk("wrap_releases", 64'(n_rel[1] - r0), 64'(256));

      // randomized stimulus against the model
      for (int k = 0; k < 24; k++) begin
         btn[0] = 1'($urandom_range(0, 1));
         repeat ($urandom_range(1, 1200)) begin
            if ($urandom_range(0, 7) == 0) btn[1] = ~btn[1];
            hold(1);
         end
      end
      btn = 2'b00;
      hold(1200);
      chk("final_q0_empty", 64'(exp_q0.size()), 64'(0));
      chk("final_q1_empty", 64'(exp_q1.size()), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
